// File: rtl/aes_mem_pkg.sv
// Shared types for the AES memory-side burst controller: FSM state encoding
// and the burst direction constants carried on the mode input.
package aes_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic MODE_READ  = 1'b0;  // encrypt source fetch
  localparam logic MODE_WRITE = 1'b1;  // decrypt result store

  function automatic logic is_active(state_t s);
    return (s == READ) || (s == WRITE);
  endfunction

endpackage

// File: rtl/sram_burst_controller_if.sv
// Requester and SRAM-side signals of the burst controller, bundled so the
// controller and its user share a single port.
interface sram_burst_controller_if #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
);
  logic              start;
  logic              mode;
  logic              key_ready;
  logic              abort;
  logic [ADDR_W-1:0] base_addr;
  logic [LEN_W-1:0]  len;
  logic              mem_ack;
  logic              r_en;
  logic              w_en;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic              done;
  logic              wrapped;

  modport master (
    output start, mode, key_ready, abort, base_addr, len, mem_ack,
    input  r_en, w_en, addr, busy, done, wrapped
  );

  modport slave (
    input  start, mode, key_ready, abort, base_addr, len, mem_ack,
    output r_en, w_en, addr, busy, done, wrapped
  );
endinterface

// File: rtl/burst_addr_counter.sv
// Address / remaining-word counter shared by read and write bursts. Load
// wins over step; wrap_pulse flags the all-ones to zero address increment.
module burst_addr_counter #(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] base,
  input  logic [LEN_W-1:0]  len,
  output logic [ADDR_W-1:0] addr,
  output logic              last,
  output logic              wrap_pulse
);

  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load) begin
      addr_q <= base;
      rem_q  <= len;
    end else if (step) begin
      addr_q <= addr_q + ADDR_W'(1);
      rem_q  <= rem_q - LEN_W'(1);
    end
  end

  assign addr       = addr_q;
  assign last       = (rem_q == LEN_W'(1));
  assign wrap_pulse = step && !load && (addr_q == '1);

endmodule

// File: rtl/sram_burst_controller.sv
// Burst sequencer between the AES datapath and a single-port SRAM: issues
// len acknowledged reads or writes from base_addr, with key gating and abort.
module sram_burst_controller
  import aes_mem_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int LEN_W  = 8
) (
  input  logic                     clk,
  input  logic                     n_rst,
  sram_burst_controller_if.slave   bus
);

  state_t state;
  logic   wrapped_q;
  logic   load;
  logic   step;
  logic   last;
  logic   wrap_pulse;
  logic   active;
  logic   launch;

  assign active = is_active(state);
  assign load   = (state == IDLE);
  // An aborting cycle never counts as an access, even if the SRAM acked it.
  assign step   = active && bus.mem_ack && !bus.abort;
  // Writes must wait for the round keys; reads may start at once.
  assign launch = bus.start && ((bus.mode == MODE_READ) || bus.key_ready);

  burst_addr_counter #(
    .ADDR_W (ADDR_W),
    .LEN_W  (LEN_W)
  ) u_counter (
    .clk        (clk),
    .n_rst      (n_rst),
    .load       (load),
    .step       (step),
    .base       (bus.base_addr),
    .len        (bus.len),
    .addr       (bus.addr),
    .last       (last),
    .wrap_pulse (wrap_pulse)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      wrapped_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          wrapped_q <= 1'b0;
          if (launch) begin
            if (bus.len == '0)
              state <= DONE;
            else
              state <= (bus.mode == MODE_WRITE) ? WRITE : READ;
          end
        end
        READ, WRITE: begin
          if (bus.abort) begin
            state <= IDLE;
          end else begin
            if (wrap_pulse)
              wrapped_q <= 1'b1;
            if (bus.mem_ack && last)
              state <= DONE;
          end
        end
        DONE: begin
          // Requester dropping start is the acknowledge of done.
          if (!bus.start)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.r_en    = (state == READ);
  assign bus.w_en    = (state == WRITE);
  assign bus.busy    = active;
  assign bus.done    = (state == DONE);
  assign bus.wrapped = wrapped_q;

endmodule

// File: tb/tb_sram_burst_controller.sv
// Scoreboard bench: stimulus pushes the expected access stream per burst,
// a negedge monitor pops and compares whatever the controller presents.
module tb_sram_burst_controller;

  logic clk;
  logic n_rst;

  sram_burst_controller_if #(.ADDR_W(8), .LEN_W(8)) bus ();

  sram_burst_controller #(.ADDR_W(8), .LEN_W(8)) dut (
    .clk   (clk),
    .n_rst (n_rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit       is_done;
    bit       wr;
    bit [7:0] a;
    bit       wrp;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every strobe cycle is compared to the head of the queue; only
  // acknowledged (non-aborting) cycles consume it. Rising done pops a done item.
  bit done_q = 1'b0;
  always @(negedge clk) begin
    if (!n_rst) begin
      done_q = 1'b0;
    end else begin
      check("strobe_exclusive", int'(bus.r_en && bus.w_en), 0);
      if ((bus.r_en || bus.w_en) && !bus.abort) begin
        if (q.size() == 0 || q[0].is_done) begin
          check("unexpected_access", 1, 0);
        end else begin
          check("access_kind", int'(bus.w_en), int'(q[0].wr));
          check("access_addr", int'(bus.addr), int'(q[0].a));
          check("access_wrapped", int'(bus.wrapped), int'(q[0].wrp));
          if (bus.mem_ack) void'(q.pop_front());
        end
      end
      if (bus.done && !done_q) begin
        if (q.size() == 0 || !q[0].is_done) begin
          check("unexpected_done", 1, 0);
        end else begin
          check("done_addr", int'(bus.addr), int'(q[0].a));
          check("done_wrapped", int'(bus.wrapped), int'(q[0].wrp));
          void'(q.pop_front());
        end
      end
      done_q = bus.done;
    end
  end

  // One burst from IDLE. abort_at: 1-based access index carrying abort (0 = none).
  // pat_len > 0 replaces the random ack with pat[] on successive strobe cycles.
  task automatic burst(input bit m, input int b, input int l, input int ack_pct,
                       input int abort_at, input int key_delay,
                       input logic [15:0] pat, input int pat_len);
    int  n_acc;
    int  acks;
    int  scyc;
    int  cyc;
    bit  aborted;
    bit  will_abort;
    exp_t e;
    will_abort = (abort_at > 0) && (abort_at <= l);
    n_acc = will_abort ? abort_at - 1 : l;
    for (int i = 0; i < n_acc; i++) begin
      e.is_done = 1'b0; e.wr = m; e.a = 8'((b + i) % 256); e.wrp = ((b + i) >= 256);
      q.push_back(e);
    end
    if (!will_abort) begin
      e.is_done = 1'b1; e.wr = m; e.a = 8'((b + l) % 256); e.wrp = ((b + l) >= 256);
      q.push_back(e);
    end

    bus.mode      = m;
    bus.base_addr = 8'(b);
    bus.len       = 8'(l);
    bus.abort     = 1'b0;
    bus.mem_ack   = 1'b0;
    bus.key_ready = !(m && key_delay > 0);
    bus.start     = 1'b1;
    if (m && key_delay > 0) begin
      for (int k = 0; k < key_delay; k++) begin
        tick();
        check("key_gate_busy", int'(bus.busy), 0);
        check("key_gate_done", int'(bus.done), 0);
      end
      bus.key_ready = 1'b1;
      tick();
      if (l != 0) check("write_after_key", int'(bus.w_en), 1);
      else        check("done_after_key", int'(bus.done), 1);
    end

    acks = 0; scyc = 0; aborted = 1'b0;
    for (cyc = 0; cyc < 400 && !bus.done; cyc++) begin
      if (bus.r_en || bus.w_en) begin
        if (will_abort && acks == abort_at - 1) begin
          bus.abort   = 1'b1;
          bus.start   = 1'b0;
          bus.mem_ack = 1'($urandom_range(0, 1));
          tick();
          bus.abort = 1'b0;
          check("abort_to_idle", int'(bus.busy), 0);
          check("abort_no_done", int'(bus.done), 0);
          aborted = 1'b1;
          break;
        end
        if (pat_len > 0) bus.mem_ack = (scyc < pat_len) ? pat[scyc] : 1'b1;
        else             bus.mem_ack = ($urandom_range(0, 99) < ack_pct);
        if (bus.mem_ack) acks++;
        scyc++;
        // Burst parameters changed mid-burst must be ignored.
        bus.base_addr = 8'($urandom);
        bus.len       = 8'($urandom);
        bus.mode      = 1'($urandom);
      end else begin
        bus.mem_ack = 1'($urandom);
      end
      tick();
    end

    if (aborted) begin
      repeat (3) begin
        tick();
        check("abort_stays_quiet", int'(bus.done || bus.busy), 0);
      end
    end else begin
      check("done_reached", int'(bus.done), 1);
      if (pat_len > 0) check("strobe_cycles", scyc, pat_len);
      tick();
      check("done_hold", int'(bus.done), 1);
      check("done_addr_hold", int'(bus.addr), (b + l) % 256);
      bus.start = 1'b0;
      tick();
      check("done_release", int'(bus.done || bus.busy), 0);
    end
    bus.mem_ack = 1'b0;
  endtask

  task automatic reset_mid_write();
    int acks;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      e.is_done = 1'b0; e.wr = 1'b1; e.a = 8'(8'h40 + i); e.wrp = 1'b0;
      q.push_back(e);
    end
    bus.mode = 1'b1; bus.base_addr = 8'h40; bus.len = 8'd8;
    bus.key_ready = 1'b1; bus.start = 1'b1; bus.mem_ack = 1'b1;
    acks = 0;
    for (int c = 0; c < 20 && acks < 2; c++) begin
      tick();
      if (bus.w_en) acks++;
    end
    tick();
    check("third_access_live", int'(bus.w_en), 1);
    #1 n_rst = 1'b0;
    #1;
    check("rst_w_en", int'(bus.w_en), 0);
    check("rst_addr", int'(bus.addr), 0);
    check("rst_busy", int'(bus.busy), 0);
    q.delete();
    bus.start = 1'b0;
    bus.mem_ack = 1'b0;
    @(negedge clk);
    #2 n_rst = 1'b1;
    tick();
    check("post_rst_idle", int'(bus.busy || bus.done || bus.r_en || bus.w_en), 0);
  endtask

  initial begin
    n_rst = 1'b0;
    bus.start = 1'b0; bus.mode = 1'b0; bus.key_ready = 1'b0; bus.abort = 1'b0;
    bus.base_addr = 8'h00; bus.len = 8'h00; bus.mem_ack = 1'b0;
    #2;
    check("reset_r_en", int'(bus.r_en), 0);
    check("reset_w_en", int'(bus.w_en), 0);
    check("reset_busy", int'(bus.busy), 0);
    check("reset_done", int'(bus.done), 0);
    check("reset_wrapped", int'(bus.wrapped), 0);
    check("reset_addr", int'(bus.addr), 0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    burst(1'b0, 8'h10, 4, 100, 0, 0, 16'h0, 0);     // plain read
    burst(1'b1, 8'h20, 4, 100, 0, 5, 16'h0, 0);     // write held for key_ready
    burst(1'b0, 8'h10, 3, 100, 0, 0, 16'h19, 5);    // acks 1,0,0,1,1
    burst(1'b0, 8'hFE, 4, 100, 0, 0, 16'h0, 0);     // address wrap
    burst(1'b1, 8'h30, 8, 100, 2, 0, 16'h0, 0);     // abort at access 2
    burst(1'b0, 8'h55, 0, 100, 0, 0, 16'h0, 0);     // zero-length
    burst(1'b1, 8'hFF, 1, 100, 0, 0, 16'h0, 0);     // single word ending in wrap
    reset_mid_write();

    for (int r = 0; r < 24; r++) begin
      int  b;
      int  l;
      int  ab;
      bit  m;
      m  = 1'($urandom);
      b  = ($urandom_range(0, 3) == 0) ? 248 + $urandom_range(0, 7) : $urandom_range(0, 255);
      l  = $urandom_range(0, 12);
      ab = ($urandom_range(0, 4) == 0 && l > 0) ? $urandom_range(1, l) : 0;
      burst(m, b, l, $urandom_range(40, 100), ab, m ? $urandom_range(0, 3) : 0, 16'h0, 0);
    end

    repeat (3) tick();
    check("queue_drained", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
